host_cmd_router: RTL and testbench
==================================

HOST_CMD_ROUTER -- requirements
Module: host_cmd_router

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 4, giving the number of memory targets (DATA, WEIGHT, OP, HEAP).
REQ-002 SHALL have parameter WORD_WIDTH, default 64, giving the target word width; it is a multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, giving the word address width.
REQ-004 SHALL have parameter READ_LATENCY, default 2, giving the target read latency in cycles.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the maximum idle gap inside a packet.
REQ-006 SHALL have ports: clk_in  in  1  the single clock; rst_in  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: rx_byte_in  in  8  received byte; rx_valid_in  in  1  one-cycle strobe qualifying rx_byte_in.
REQ-008 SHALL have ports: tx_byte_out  out  8  byte to transmit; tx_valid_out  out  1  byte valid; tx_ready_in  in  1  transmitter ready.
REQ-009 SHALL have ports: mem_addr_out  out  ADDR_WIDTH  word address; mem_wdata_out  out  WORD_WIDTH  write word.
REQ-010 SHALL have ports: mem_we_out  out  NUM_TARGETS  one-hot write strobe; mem_re_out  out  NUM_TARGETS  one-hot read strobe.
REQ-011 SHALL have ports: mem_rdata_in  in  NUM_TARGETS*WORD_WIDTH  packed read data, target t at slice t; busy_out  out  1  packet in progress; err_out  out  1  one-cycle error pulse.

Function
REQ-012 Packet SHALL be a 5-byte header (cmd, addr_lo, addr_hi, cnt_lo, cnt_hi), followed by cnt*WORD_WIDTH/8 payload bytes for writes.
REQ-013 cmd bit7 SHALL select read (1) or write (0); cmd[6:0] SHALL be the target id; addr and cnt SHALL be little-endian; cnt counts words.
REQ-014 States SHALL be IDLE, HDR, WR_DATA, WR_DISCARD, RD_ISSUE, RD_WAIT, RD_SEND; the first rx byte SHALL move IDLE to HDR.
REQ-015 After the fifth header byte, the next state SHALL be: cnt==0 -> IDLE; target >= NUM_TARGETS -> err_out pulse, then WR_DISCARD for a write or IDLE for a read; otherwise WR_DATA or RD_ISSUE.
REQ-016 WR_DATA SHALL assemble bytes LSB-first; on the last byte of a word, mem_we_out[target] SHALL pulse exactly one cycle on the following clock with that word and its address.
REQ-017 After each word, the address SHALL increment modulo 2^ADDR_WIDTH and cnt SHALL decrement; at cnt==0 the state SHALL return to IDLE.
REQ-018 WR_DISCARD SHALL consume and drop the full payload length without any strobe.
REQ-019 RD_ISSUE SHALL pulse mem_re_out[target] for one cycle; RD_WAIT SHALL hold for READ_LATENCY cycles, then capture mem_rdata_in slice [target].
REQ-020 RD_SEND SHALL present bytes LSB-first; a byte SHALL advance only on a cycle with tx_valid_out && tx_ready_in; tx_byte_out SHALL be stable while valid and not ready.
REQ-021 After the last byte of a word: if cnt > 0 after decrement -> RD_ISSUE at address+1, else -> IDLE.
REQ-022 rx bytes arriving in any RD_* state SHALL be dropped.
REQ-023 In HDR, WR_DATA or WR_DISCARD, TIMEOUT_CYCLES cycles with no rx_valid_in SHALL pulse err_out and return to IDLE; partial words SHALL never be written.
REQ-024 busy_out SHALL be high in every state except IDLE.
REQ-025 Each of mem_we_out and mem_re_out SHALL have at most one bit set, and they SHALL never be asserted together.

Reset
REQ-026 rst_in SHALL force IDLE in every state, including mid-packet, and clear all counters and the partial word.
REQ-027 At and after reset, these outputs SHALL be 0: tx_valid_out, mem_we_out, mem_re_out, busy_out, err_out, mem_addr_out, mem_wdata_out, tx_byte_out.

Structure
REQ-028 A shared package host_pkg SHALL hold the state enum, the header length (5), the read-bit position (7), and the target ids (DATA=0, WEIGHT=1, OP=2, HEAP=3).
REQ-029 A sub-module word_serializer SHALL implement the word-to-byte valid/ready conversion.

Verification
REQ-030 Write packet 00 00 00 01 00 + 8 bytes 01..08 -> one we[0] pulse, addr 0, wdata 0x0807060504030201.
REQ-031 Read packet 80 00 00 02 00 with tx_ready toggling every cycle -> re[0] at addr 0 and at addr 1; 16 bytes sent LSB-first in order, none duplicated or lost.
REQ-032 Write packet 02 FF FF 02 00 (WORD_WIDTH=8) -> writes at addr 0xFFFF, then 0x0000.
REQ-033 Write packet 7F 00 00 01 00 + 8 bytes -> err_out pulse, no strobes, returns to IDLE after the 8th byte.
REQ-034 Header plus 3 payload bytes, then silence -> err_out after TIMEOUT_CYCLES, no we; the next packet is processed correctly.
REQ-035 rst_in asserted during RD_SEND -> tx_valid_out low next cycle, busy_out 0, and a subsequent write is accepted.

Source files
------------

// File: rtl/host_pkg.sv
// Shared definitions for the host command router: FSM states, header layout
// and memory target identifiers.
package host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR_DATA,
        ST_WR_DISCARD,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_SEND
    } state_e;

    localparam int unsigned HDR_LEN  = 5;
    localparam int unsigned READ_BIT = 7;

    localparam int unsigned TGT_DATA   = 0;
    localparam int unsigned TGT_WEIGHT = 1;
    localparam int unsigned TGT_OP     = 2;
    localparam int unsigned TGT_HEAP   = 3;

endpackage

// File: rtl/word_serializer.sv
// Converts a loaded word into a LSB-first byte stream with valid/ready
// handshaking; done_o marks the handshake of the final byte.
module word_serializer #(
    parameter int unsigned WORD_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic                  ready_i,
    output logic [7:0]            byte_o,
    output logic                  valid_o,
    output logic                  done_o
);
    localparam int unsigned NB = WORD_WIDTH / 8;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_o  = 1'b0;
        if (load_i) begin
            word_d  = word_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            if (idx_q == IW'(NB - 1)) begin
                valid_d = 1'b0;
                done_o  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign byte_o  = word_q[32'(idx_q)*8 +: 8];
    assign valid_o = valid_q;

endmodule

// File: rtl/host_cmd_router.sv
// Decodes byte-stream host packets into word reads/writes on one of several
// memory targets and streams read data back over a valid/ready byte port.
module host_cmd_router
    import host_pkg::*;
#(
    parameter int unsigned NUM_TARGETS    = 4,
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [7:0]                        rx_byte_in,
    input  logic                              rx_valid_in,
    output logic [7:0]                        tx_byte_out,
    output logic                              tx_valid_out,
    input  logic                              tx_ready_in,
    output logic [ADDR_WIDTH-1:0]             mem_addr_out,
    output logic [WORD_WIDTH-1:0]             mem_wdata_out,
    output logic [NUM_TARGETS-1:0]            mem_we_out,
    output logic [NUM_TARGETS-1:0]            mem_re_out,
    input  logic [NUM_TARGETS*WORD_WIDTH-1:0] mem_rdata_in,
    output logic                              busy_out,
    output logic                              err_out
);
    localparam int unsigned WB  = WORD_WIDTH / 8;
    localparam int unsigned BIW = (WB > 1) ? $clog2(WB) : 1;
    localparam int unsigned TW  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int unsigned IDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LW  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    state_e                 state_q, state_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [2:0]             hdr_idx_q, hdr_idx_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [BIW-1:0]         byte_idx_q, byte_idx_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic [IDW-1:0]         idle_q, idle_d;
    logic [LW-1:0]          wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
    logic [NUM_TARGETS-1:0] we_q, we_d, re_q, re_d;
    logic                   err_q, err_d;

    logic [TW-1:0]          tgt_idx;
    logic                   tgt_ok;
    logic [NUM_TARGETS-1:0] tgt_onehot;
    logic [WORD_WIDTH-1:0]  word_fill;
    logic [WORD_WIDTH-1:0]  rd_word;
    logic [15:0]            cnt_full;
    logic                   ser_load, ser_done;

    assign tgt_idx  = cmd_q[TW-1:0];
    assign tgt_ok   = 32'(cmd_q[6:0]) < NUM_TARGETS;
    assign rd_word  = mem_rdata_in[32'(tgt_idx)*WORD_WIDTH +: WORD_WIDTH];
    assign cnt_full = {rx_byte_in, cnt_q[7:0]};

    always_comb begin
        tgt_onehot          = '0;
        tgt_onehot[tgt_idx] = 1'b1;
        word_fill                          = word_q;
        word_fill[32'(byte_idx_q)*8 +: 8]  = rx_byte_in;
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        hdr_idx_d  = hdr_idx_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        idle_d     = idle_q;
        wait_d     = wait_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        we_d       = '0;
        re_d       = '0;
        err_d      = 1'b0;
        ser_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid_in) begin
                    cmd_d     = rx_byte_in;
                    hdr_idx_d = 3'd1;
                    idle_d    = '0;
                    state_d   = ST_HDR;
                end
            end

            ST_HDR, ST_WR_DATA, ST_WR_DISCARD: begin
                if (!rx_valid_in) begin
                    if (idle_q == IDW'(TIMEOUT_CYCLES - 1)) begin
                        err_d      = 1'b1;
                        word_d     = '0;
                        byte_idx_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    idle_d = '0;
                    if (state_q == ST_HDR) begin
                        hdr_idx_d = hdr_idx_q + 1'b1;
                        case (hdr_idx_q)
                            3'd1: addr_d = ADDR_WIDTH'({8'h00, rx_byte_in});
                            3'd2: addr_d = ADDR_WIDTH'({rx_byte_in, addr_q[7:0]});
                            3'd3: cnt_d  = {8'h00, rx_byte_in};
                            default: begin
                                cnt_d      = cnt_full;
                                byte_idx_d = '0;
                                word_d     = '0;
                                if (cnt_full == 16'd0) begin
                                    state_d = ST_IDLE;
                                end else if (!tgt_ok) begin
                                    // Bad target still has its payload drained so framing stays aligned.
                                    err_d   = 1'b1;
                                    state_d = cmd_q[READ_BIT] ? ST_IDLE : ST_WR_DISCARD;
                                end else begin
                                    state_d = cmd_q[READ_BIT] ? ST_RD_ISSUE : ST_WR_DATA;
                                end
                            end
                        endcase
                    end else if (byte_idx_q == BIW'(WB - 1)) begin
                        byte_idx_d = '0;
                        word_d     = '0;
                        if (state_q == ST_WR_DATA) begin
                            we_d       = tgt_onehot;
                            wdata_d    = word_fill;
                            mem_addr_d = addr_q;
                        end
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                        if (cnt_q == 16'd1) state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        word_d     = word_fill;
                    end
                end
            end

            ST_RD_ISSUE: begin
                re_d       = tgt_onehot;
                mem_addr_d = addr_q;
                wait_d     = '0;
                state_d    = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                if (wait_q == LW'(READ_LATENCY)) begin
                    ser_load = 1'b1;
                    state_d  = ST_RD_SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            ST_RD_SEND: begin
                if (ser_done) begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_RD_ISSUE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            hdr_idx_q  <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            idle_q     <= '0;
            wait_q     <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            re_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            hdr_idx_q  <= hdr_idx_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            idle_q     <= idle_d;
            wait_q     <= wait_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            err_q      <= err_d;
        end
    end

    word_serializer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_ser (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .load_i (ser_load),
        .word_i (rd_word),
        .ready_i(tx_ready_in),
        .byte_o (tx_byte_out),
        .valid_o(tx_valid_out),
        .done_o (ser_done)
    );

    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = wdata_q;
    assign mem_we_out    = we_q;
    assign mem_re_out    = re_q;
    assign err_out       = err_q;
    assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_host_cmd_router.sv
// Directed bench for host_cmd_router: a 64-bit instance for most scenarios and
// an 8-bit-word instance for address wrap.
module tb_host_cmd_router;

    localparam int unsigned TO = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_byte = '0;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [15:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [3:0]   mem_we, mem_re;
    logic [255:0] mem_rdata = {4{64'hDEAD_BEEF_CAFE_F00D}};
    logic         busy, err;

    logic [7:0]   rx8_byte = '0;
    logic         rx8_valid = 1'b0;
    logic [7:0]   tx8_byte;
    logic         tx8_valid;
    logic         tx8_ready = 1'b1;
    logic [15:0]  mem8_addr;
    logic [7:0]   mem8_wdata;
    logic [3:0]   mem8_we, mem8_re;
    logic [31:0]  mem8_rdata = '0;
    logic         busy8, err8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    host_cmd_router #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk_in(clk), .rst_in(rst), .rx_byte_in(rx_byte), .rx_valid_in(rx_valid),
        .tx_byte_out(tx_byte), .tx_valid_out(tx_valid), .tx_ready_in(tx_ready),
        .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata), .mem_we_out(mem_we),
        .mem_re_out(mem_re), .mem_rdata_in(mem_rdata), .busy_out(busy), .err_out(err)
    );

    host_cmd_router #(.WORD_WIDTH(8), .TIMEOUT_CYCLES(TO)) u_dut8 (
        .clk_in(clk), .rst_in(rst), .rx_byte_in(rx8_byte), .rx_valid_in(rx8_valid),
        .tx_byte_out(tx8_byte), .tx_valid_out(tx8_valid), .tx_ready_in(tx8_ready),
        .mem_addr_out(mem8_addr), .mem_wdata_out(mem8_wdata), .mem_we_out(mem8_we),
        .mem_re_out(mem8_re), .mem_rdata_in(mem8_rdata), .busy_out(busy8), .err_out(err8)
    );

    // Target 0 memory with two-cycle read latency: word at address a holds
    // bytes (0x10*(a+1) + j) for byte lane j.
    logic        p_v = 1'b0;
    logic [15:0] p_a = '0;
    function automatic logic [63:0] rd_pattern(input logic [15:0] a);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8'h10 * (a + 16'd1) + 8'(j));
        return w;
    endfunction
    always @(posedge clk) begin
        p_v <= |mem_re;
        p_a <= mem_addr;
        if (p_v) mem_rdata[63:0] <= rd_pattern(p_a);
    end

    logic [15:0] we_a[$];
    logic [63:0] we_d[$];
    logic [3:0]  we_v[$];
    logic [15:0] re_a[$];
    logic [3:0]  re_v[$];
    logic [7:0]  tx_q[$];
    logic [15:0] we8_a[$];
    logic [7:0]  we8_d[$];
    logic [3:0]  we8_v[$];
    int          err_cnt = 0;
    int          proto_bad = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;

    always @(negedge clk) begin
        if (mem_we != 0) begin we_a.push_back(mem_addr); we_d.push_back(mem_wdata); we_v.push_back(mem_we); end
        if (mem_re != 0) begin re_a.push_back(mem_addr); re_v.push_back(mem_re); end
        if (mem8_we != 0) begin we8_a.push_back(mem8_addr); we8_d.push_back(mem8_wdata); we8_v.push_back(mem8_we); end
        if ($countones(mem_we) > 1 || $countones(mem_re) > 1 || (mem_we != 0 && mem_re != 0)) proto_bad++;
        if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
        if (prev_stall && tx_valid && tx_byte !== prev_byte) proto_bad++;
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
        if (err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] b);
        rx8_byte = b; rx8_valid = 1'b1; tick(); rx8_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL reset_we got=%h exp=0", mem_we); end
        total++; if (mem_re !== 4'h0) begin bad++; $display("FAIL reset_re got=%h exp=0", mem_re); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 64'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        total++; if (tx_byte !== 8'h0) begin bad++; $display("FAIL reset_tx_byte got=%h exp=0", tx_byte); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int b = we_a.size();
        int e = err_cnt;
        send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
        for (int i = 1; i <= 8; i++) send(8'(i));
        repeat (3) tick();
        total++; if (we_a.size() - b != 1) begin bad++; $display("FAIL write_count got=%0d exp=1", we_a.size() - b); end
        else begin
            total++; if (we_v[b] !== 4'b0001) begin bad++; $display("FAIL write_we got=%b exp=0001", we_v[b]); end
            total++; if (we_a[b] !== 16'h0000) begin bad++; $display("FAIL write_addr got=%h exp=0000", we_a[b]); end
            total++; if (we_d[b] !== 64'h0807060504030201) begin bad++; $display("FAIL write_data got=%h exp=0807060504030201", we_d[b]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_idle busy=%b exp=0", busy); end
        total++; if (err_cnt != e) begin bad++; $display("FAIL write_err got=%0d exp=0", err_cnt - e); end
    endtask

    task automatic test_read_backpressure();
        int rb = re_a.size();
        int tb = tx_q.size();
        logic [7:0] exp;
        tx_ready = 1'b0;
        send(8'h80); send(8'h00); send(8'h00); send(8'h02); send(8'h00);
        for (int i = 0; i < 300; i++) begin
            if (tx_q.size() - tb == 16 && !busy) break;
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b0;
        repeat (2) tick();
        total++; if (re_a.size() - rb != 2) begin bad++; $display("FAIL read_re_count got=%0d exp=2", re_a.size() - rb); end
        else begin
            total++; if (re_a[rb] !== 16'h0 || re_v[rb] !== 4'b0001) begin bad++; $display("FAIL read_re0 addr=%h re=%b exp=0000/0001", re_a[rb], re_v[rb]); end
            total++; if (re_a[rb+1] !== 16'h1 || re_v[rb+1] !== 4'b0001) begin bad++; $display("FAIL read_re1 addr=%h re=%b exp=0001/0001", re_a[rb+1], re_v[rb+1]); end
        end
        total++; if (tx_q.size() - tb != 16) begin bad++; $display("FAIL read_byte_count got=%0d exp=16", tx_q.size() - tb); end
        else begin
            for (int k = 0; k < 16; k++) begin
                exp = (k < 8) ? 8'(8'h10 + k) : 8'(8'h20 + k - 8);
                total++; if (tx_q[tb+k] !== exp) begin bad++; $display("FAIL read_byte%0d got=%h exp=%h", k, tx_q[tb+k], exp); end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_addr_wrap();
        int b = we8_a.size();
        send8(8'h02); send8(8'hFF); send8(8'hFF); send8(8'h02); send8(8'h00);
        send8(8'hAA); send8(8'hBB);
        repeat (3) tick();
        total++; if (we8_a.size() - b != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", we8_a.size() - b); end
        else begin
            total++; if (we8_a[b] !== 16'hFFFF || we8_d[b] !== 8'hAA || we8_v[b] !== 4'b0100) begin bad++; $display("FAIL wrap_first addr=%h data=%h we=%b exp=FFFF/AA/0100", we8_a[b], we8_d[b], we8_v[b]); end
            total++; if (we8_a[b+1] !== 16'h0000 || we8_d[b+1] !== 8'hBB || we8_v[b+1] !== 4'b0100) begin bad++; $display("FAIL wrap_second addr=%h data=%h we=%b exp=0000/BB/0100", we8_a[b+1], we8_d[b+1], we8_v[b+1]); end
        end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL wrap_idle busy=%b exp=0", busy8); end
    endtask

    task automatic test_bad_target();
        int wb = we_a.size();
        int rb = re_a.size();
        int e = err_cnt;
        send(8'h7F); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
        tick();
        total++; if (err_cnt - e != 1) begin bad++; $display("FAIL badtgt_err got=%0d exp=1", err_cnt - e); end
        for (int i = 0; i < 7; i++) send(8'hC0 + 8'(i));
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL badtgt_busy_mid got=%b exp=1", busy); end
        send(8'hC7);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL badtgt_idle got=%b exp=0", busy); end
        repeat (2) tick();
        total++; if (we_a.size() != wb || re_a.size() != rb) begin bad++; $display("FAIL badtgt_strobes we=%0d re=%0d exp=0/0", we_a.size() - wb, re_a.size() - rb); end
    endtask

    task automatic test_timeout();
        int wb = we_a.size();
        int e = err_cnt;
        int n;
        send(8'h00); send(8'h10); send(8'h00); send(8'h01); send(8'h00);
        send(8'hA1); send(8'hA2); send(8'hA3);
        for (n = 1; n <= 200; n++) begin
            tick();
            if (err) break;
        end
        total++; if (n < int'(TO) - 1 || n > int'(TO) + 1) begin bad++; $display("FAIL timeout_delay got=%0d exp=%0d", n, TO); end
        repeat (2) tick();
        total++; if (err_cnt - e != 1) begin bad++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle busy=%b exp=0", busy); end
        total++; if (we_a.size() != wb) begin bad++; $display("FAIL timeout_no_we got=%0d exp=0", we_a.size() - wb); end
        send(8'h00); send(8'h05); send(8'h00); send(8'h01); send(8'h00);
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
        repeat (3) tick();
        total++; if (we_a.size() - wb != 1) begin bad++; $display("FAIL timeout_next_count got=%0d exp=1", we_a.size() - wb); end
        else begin
            total++; if (we_a[wb] !== 16'h0005 || we_d[wb] !== 64'h1817161514131211) begin bad++; $display("FAIL timeout_next addr=%h data=%h exp=0005/1817161514131211", we_a[wb], we_d[wb]); end
        end
    endtask

    task automatic test_zero_count();
        int wb = we_a.size();
        send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zerocnt_idle busy=%b exp=0", busy); end
        repeat (2) tick();
        total++; if (we_a.size() != wb) begin bad++; $display("FAIL zerocnt_we got=%0d exp=0", we_a.size() - wb); end
    endtask

    task automatic test_reset_mid_read();
        int wb;
        int i;
        tx_ready = 1'b0;
        send(8'h80); send(8'h00); send(8'h00); send(8'h02); send(8'h00);
        for (i = 0; i < 50; i++) begin
            if (tx_valid) break;
            tick();
        end
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rstread_reach_send tx_valid=%b exp=1", tx_valid); end
        rst = 1'b1;
        tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rstread_tx_valid got=%b exp=0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstread_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tx_ready = 1'b1;
        tick();
        wb = we_a.size();
        send(8'h00); send(8'h07); send(8'h00); send(8'h01); send(8'h00);
        for (int k = 0; k < 8; k++) send(8'hE0 + 8'(k));
        repeat (3) tick();
        total++; if (we_a.size() - wb != 1) begin bad++; $display("FAIL rstread_next_count got=%0d exp=1", we_a.size() - wb); end
        else begin
            total++; if (we_a[wb] !== 16'h0007 || we_d[wb] !== 64'hE7E6E5E4E3E2E1E0) begin bad++; $display("FAIL rstread_next addr=%h data=%h exp=0007/E7E6E5E4E3E2E1E0", we_a[wb], we_d[wb]); end
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rstread_no_stale_tx got=%b exp=0", tx_valid); end
    endtask

    task automatic test_protocol();
        total++; if (proto_bad != 0) begin bad++; $display("FAIL protocol_violations got=%0d exp=0", proto_bad); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_addr_wrap();
        test_bad_target();
        test_timeout();
        test_zero_count();
        test_reset_mid_read();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
